// File: rtl/rx_watchdog_pkg.sv
// Shared types and constants for the multi-channel receiver watchdog.
// Holds the FSM encoding, reset-cause bit positions and the statistics counter helper.
package rx_watchdog_pkg;

   typedef enum logic [1:0] {
      WD_IDLE    = 2'd0,
      WD_MONITOR = 2'd1,
      WD_PULSE   = 2'd2,
      WD_HOLDOFF = 2'd3
   } wd_state_e;

   localparam int CAUSE_DC    = 0;
   localparam int CAUSE_LEN   = 1;
   localparam int CAUSE_TO    = 2;
   localparam int CAUSE_W     = 3;
   localparam int RST_COUNT_W = 16;

   function automatic logic [RST_COUNT_W-1:0] sat_inc(input logic [RST_COUNT_W-1:0] v);
      if (&v) begin
         sat_inc = v;
      end else begin
         sat_inc = v + {{(RST_COUNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

endpackage

// File: rtl/rx_signal_watchdog_mc_if.sv
// Receive-path stream seen by the watchdog: IQ samples plus demodulator status pulses.
// The receiver front end drives it as master; the watchdog observes it as slave.
interface rx_signal_watchdog_mc_if #(
   parameter int NUM_CH        = 2,
   parameter int IQ_DATA_WIDTH = 16,
   parameter int LEN_WIDTH     = 16
);
   logic [NUM_CH*2*IQ_DATA_WIDTH-1:0] sample_in;
   logic                              sample_in_strobe;
   logic                              power_trigger;
   logic                              demod_is_ongoing;
   logic                              pkt_done;
   logic                              sig_valid;
   logic [LEN_WIDTH-1:0]              signal_len;

   modport master (
      output sample_in, sample_in_strobe, power_trigger,
      output demod_is_ongoing, pkt_done, sig_valid, signal_len
   );

   modport slave (
      input sample_in, sample_in_strobe, power_trigger,
      input demod_is_ongoing, pkt_done, sig_valid, signal_len
   );
endinterface

// File: rtl/rx_signal_watchdog_mc_dc_sign_detector.sv
// One channel's sign-balance detector: counts +1/-1 per I and Q sign over a fixed window
// and flags the channel when either running sum reaches the threshold at window end.
module dc_sign_detector #(
   parameter int IQ_DATA_WIDTH = 16,
   parameter int DC_WIN_LOG2   = 6
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       active,
   input  logic                       strobe,
   input  logic [2*IQ_DATA_WIDTH-1:0] sample,
   input  logic [7:0]                 th,
   output logic                       flag
);
   localparam int SUM_W = DC_WIN_LOG2 + 2;
   localparam int CMP_W = (SUM_W > 8) ? SUM_W : 8;

   logic signed [SUM_W-1:0]   sum_i_r, sum_q_r, sum_i_s, sum_q_s;
   logic [SUM_W-1:0]          mag_i_s, mag_q_s;
   logic [DC_WIN_LOG2-1:0]    win_cnt_r;
   logic                      last_s;

   function automatic logic signed [SUM_W-1:0] step(input logic signed [SUM_W-1:0] s,
                                                    input logic neg);
      if (neg) begin
         step = s - SUM_W'(1);
      end else begin
         step = s + SUM_W'(1);
      end
   endfunction

   function automatic logic [SUM_W-1:0] mag(input logic signed [SUM_W-1:0] s);
      if (s[SUM_W-1]) begin
         mag = -s;
      end else begin
         mag = s;
      end
   endfunction

   // Sums including the current sample, so the last strobe of a window is counted.
   always_comb begin
      sum_i_s = step(sum_i_r, sample[2*IQ_DATA_WIDTH-1]);
      sum_q_s = step(sum_q_r, sample[IQ_DATA_WIDTH-1]);
      mag_i_s = mag(sum_i_s);
      mag_q_s = mag(sum_q_s);
      last_s  = &win_cnt_r;
      flag    = active & strobe & last_s & (th != 8'd0) &
                ((CMP_W'(mag_i_s) >= CMP_W'(th)) | (CMP_W'(mag_q_s) >= CMP_W'(th)));
   end

   // Accumulators restart at window end and whenever the channel is not being checked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_i_r   <= '0;
         sum_q_r   <= '0;
         win_cnt_r <= '0;
      end else if (!active || (strobe && last_s)) begin
         sum_i_r   <= '0;
         sum_q_r   <= '0;
         win_cnt_r <= '0;
      end else if (strobe) begin
         sum_i_r   <= sum_i_s;
         sum_q_r   <= sum_q_s;
         win_cnt_r <= win_cnt_r + DC_WIN_LOG2'(1);
      end
   end
endmodule

// File: rtl/rx_signal_watchdog_mc.sv
// Receiver watchdog: DC/stuck-sign, SIG length and demod timeout checks feeding a
// reset-pulse / holdoff sequencer with a cause mask and saturating event counter.
module rx_signal_watchdog_mc
   import rx_watchdog_pkg::*;
#(
   parameter int NUM_CH        = 2,
   parameter int IQ_DATA_WIDTH = 16,
   parameter int DC_WIN_LOG2   = 6,
   parameter int LEN_WIDTH     = 16,
   parameter int TIMEOUT_WIDTH = 20,
   parameter int RST_PULSE_LEN = 4,
   parameter int HOLDOFF_LEN   = 16
) (
   input  logic                     s00_axi_aclk,
   input  logic                     s00_axi_aresetn,
   input  logic                     enable,
   rx_signal_watchdog_mc_if.slave   rx,
   input  logic [NUM_CH-1:0]        ch_mask,
   input  logic [LEN_WIDTH-1:0]     min_signal_len_th,
   input  logic [LEN_WIDTH-1:0]     max_signal_len_th,
   input  logic [7:0]               dc_running_sum_th,
   input  logic [TIMEOUT_WIDTH-1:0] timeout_th,
   input  logic                     clear_stats,
   output logic                     receiver_rst,
   output logic [CAUSE_W-1:0]       rst_cause,
   output logic [RST_COUNT_W-1:0]   rst_count,
   output logic [1:0]               wd_state
);
   localparam int SEQ_LEN = (RST_PULSE_LEN > HOLDOFF_LEN) ? RST_PULSE_LEN : HOLDOFF_LEN;
   localparam int SEQ_W   = $clog2(SEQ_LEN + 1);

   wd_state_e                 state_r, state_s;
   logic [SEQ_W-1:0]          seq_cnt_r, seq_cnt_s;
   logic [TIMEOUT_WIDTH-1:0]  to_cnt_r;
   logic [NUM_CH-1:0]         dc_flag_s;
   logic [CAUSE_W-1:0]        fault_s, rst_cause_r;
   logic [RST_COUNT_W-1:0]    rst_count_r;
   logic                      receiver_rst_r, monitor_s, event_s;

   assign monitor_s = (state_r == WD_MONITOR);

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      dc_sign_detector #(
         .IQ_DATA_WIDTH (IQ_DATA_WIDTH),
         .DC_WIN_LOG2   (DC_WIN_LOG2)
      ) u_dc (
         .clk    (s00_axi_aclk),
         .rst_n  (s00_axi_aresetn),
         .active (monitor_s & rx.power_trigger & ~rx.demod_is_ongoing & ch_mask[k]),
         .strobe (rx.sample_in_strobe),
         .sample (rx.sample_in[k*2*IQ_DATA_WIDTH +: 2*IQ_DATA_WIDTH]),
         .th     (dc_running_sum_th),
         .flag   (dc_flag_s[k])
      );
   end

   // Fault sources for this cycle; only a cycle spent in MONITOR can raise an event.
   always_comb begin
      fault_s            = 3'b000;
      fault_s[CAUSE_DC]  = |(dc_flag_s & ch_mask);
      fault_s[CAUSE_LEN] = monitor_s & rx.sig_valid &
                           ((rx.signal_len < min_signal_len_th) ||
                            (rx.signal_len > max_signal_len_th));
      fault_s[CAUSE_TO]  = monitor_s & rx.demod_is_ongoing & ~rx.pkt_done &
                           (timeout_th != {TIMEOUT_WIDTH{1'b0}}) &
                           ((to_cnt_r + TIMEOUT_WIDTH'(1)) == timeout_th);
      event_s            = monitor_s & enable & (|fault_s);
   end

   // Next-state logic; seq_cnt only runs inside PULSE and HOLDOFF.
   always_comb begin
      state_s   = state_r;
      seq_cnt_s = seq_cnt_r;
      case (state_r)
         WD_IDLE: begin
            if (enable) state_s = WD_MONITOR;
            else        state_s = WD_IDLE;
         end
         WD_MONITOR: begin
            if (!enable) begin
               state_s = WD_IDLE;
            end else if (event_s) begin
               state_s   = WD_PULSE;
               seq_cnt_s = {SEQ_W{1'b0}};
            end else begin
               state_s = WD_MONITOR;
            end
         end
         WD_PULSE: begin
            if (seq_cnt_r == SEQ_W'(RST_PULSE_LEN - 1)) begin
               state_s   = WD_HOLDOFF;
               seq_cnt_s = {SEQ_W{1'b0}};
            end else begin
               seq_cnt_s = seq_cnt_r + SEQ_W'(1);
            end
         end
         WD_HOLDOFF: begin
            if (seq_cnt_r == SEQ_W'(HOLDOFF_LEN - 1)) begin
               state_s   = enable ? WD_MONITOR : WD_IDLE;
               seq_cnt_s = {SEQ_W{1'b0}};
            end else begin
               seq_cnt_s = seq_cnt_r + SEQ_W'(1);
            end
         end
         default: begin
            state_s   = WD_IDLE;
            seq_cnt_s = {SEQ_W{1'b0}};
         end
      endcase
   end

   // State, sequencer counter and registered reset output.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state_r        <= WD_IDLE;
         seq_cnt_r      <= {SEQ_W{1'b0}};
         receiver_rst_r <= 1'b0;
      end else begin
         state_r        <= state_s;
         seq_cnt_r      <= seq_cnt_s;
         receiver_rst_r <= (state_s == WD_PULSE);
      end
   end

   // Demod timeout counter, saturating so a stuck demod cannot wrap into a false match.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         to_cnt_r <= {TIMEOUT_WIDTH{1'b0}};
      end else if (monitor_s && rx.demod_is_ongoing && !rx.pkt_done) begin
         to_cnt_r <= (&to_cnt_r) ? to_cnt_r : to_cnt_r + TIMEOUT_WIDTH'(1);
      end else begin
         to_cnt_r <= {TIMEOUT_WIDTH{1'b0}};
      end
   end

   // Status record; a coincident clear request beats a new event.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         rst_cause_r <= 3'b000;
         rst_count_r <= {RST_COUNT_W{1'b0}};
      end else if (clear_stats) begin
         rst_cause_r <= 3'b000;
         rst_count_r <= {RST_COUNT_W{1'b0}};
      end else if (event_s) begin
         rst_cause_r <= fault_s;
         rst_count_r <= sat_inc(rst_count_r);
      end
   end

   assign receiver_rst = receiver_rst_r;
   assign rst_cause    = rst_cause_r;
   assign rst_count    = rst_count_r;
   assign wd_state     = state_r;
endmodule

// File: tb/tb_rx_signal_watchdog_mc.sv
// Directed self-checking bench for rx_signal_watchdog_mc: DC, length, timeout,
// simultaneous faults, holdoff suppression and asynchronous reset during a pulse.
module tb_rx_signal_watchdog_mc;
   localparam logic [15:0] POS = 16'h0064;
   localparam logic [15:0] NEG = 16'hFF9C;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [1:0]  ch_mask;
   logic [15:0] min_th, max_th;
   logic [7:0]  dc_th;
   logic [19:0] timeout_th;
   logic        clear_stats;
   logic        receiver_rst;
   logic [2:0]  rst_cause;
   logic [15:0] rst_count;
   logic [1:0]  wd_state;

   int n_checks = 0;
   int n_errors = 0;
   int exp_count = 0;

   always #5 clk = ~clk;

   rx_signal_watchdog_mc_if #(.NUM_CH(2), .IQ_DATA_WIDTH(16), .LEN_WIDTH(16)) rx_if ();

   rx_signal_watchdog_mc dut (
      .s00_axi_aclk      (clk),
      .s00_axi_aresetn   (rst_n),
      .enable            (enable),
      .rx                (rx_if.slave),
      .ch_mask           (ch_mask),
      .min_signal_len_th (min_th),
      .max_signal_len_th (max_th),
      .dc_running_sum_th (dc_th),
      .timeout_th        (timeout_th),
      .clear_stats       (clear_stats),
      .receiver_rst      (receiver_rst),
      .rst_cause         (rst_cause),
      .rst_count         (rst_count),
      .wd_state          (wd_state)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives n strobes; ch0 alternates between a0 and a1, ch1 fixed. Reports any reset seen.
   task automatic dc_stream(input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] c1, input int n, output bit saw_rst);
      saw_rst = 1'b0;
      for (int i = 0; i < n; i++) begin
         rx_if.sample_in        = {c1, (i % 2 == 0) ? a0 : a1};
         rx_if.sample_in_strobe = 1'b1;
         tick();
         if (receiver_rst) saw_rst = 1'b1;
      end
      rx_if.sample_in_strobe = 1'b0;
   endtask

   // Called with receiver_rst just observed high: measures pulse and holdoff lengths.
   task automatic pulse_and_holdoff(input string tag);
      int hi = 0;
      int ho = 0;
      while (receiver_rst === 1'b1 && hi < 20) begin
         hi++;
         tick();
      end
      check_eq({tag, "_pulse_len"}, hi, 4);
      check_eq({tag, "_holdoff_state"}, wd_state, 2'd3);
      while (wd_state !== 2'd1 && ho < 100) begin
         ho++;
         tick();
      end
      check_eq({tag, "_holdoff_len"}, ho, 16);
   endtask

   task automatic sig_pulse(input logic [15:0] len);
      rx_if.signal_len = len;
      rx_if.sig_valid  = 1'b1;
      tick();
      rx_if.sig_valid  = 1'b0;
   endtask

   initial begin
      bit saw;
      int n;
      rst_n = 1'b0; enable = 1'b0; ch_mask = 2'b00; clear_stats = 1'b0;
      min_th = 16'd0; max_th = 16'hFFFF; dc_th = 8'd0; timeout_th = 20'd0;
      rx_if.sample_in = '0; rx_if.sample_in_strobe = 1'b0; rx_if.power_trigger = 1'b0;
      rx_if.demod_is_ongoing = 1'b0; rx_if.pkt_done = 1'b0; rx_if.sig_valid = 1'b0;
      rx_if.signal_len = 16'd0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check_eq("reset_rst", receiver_rst, 1'b0);
      check_eq("reset_cause", rst_cause, 3'b000);
      check_eq("reset_count", rst_count, 16'd0);
      check_eq("reset_state", wd_state, 2'd0);
      enable = 1'b1;
      tick();
      check_eq("enter_monitor", wd_state, 2'd1);

      // DC stuck on channel 0
      dc_th = 8'd48; ch_mask = 2'b01; rx_if.power_trigger = 1'b1;
      dc_stream({POS, POS}, {POS, POS}, 32'h0, 63, saw);
      check_eq("dc_no_early_rst", saw, 1'b0);
      dc_stream({POS, POS}, {POS, POS}, 32'h0, 1, saw);
      exp_count++;
      check_eq("dc_rst", receiver_rst, 1'b1);
      check_eq("dc_cause", rst_cause, 3'b001);
      check_eq("dc_count", rst_count, exp_count);
      check_eq("dc_state", wd_state, 2'd2);
      pulse_and_holdoff("dc");

      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      exp_count = 0;
      check_eq("clear_count", rst_count, 16'd0);
      check_eq("clear_cause", rst_cause, 3'b000);

      // Stuck channel 1 is masked, channel 0 balanced
      dc_stream({POS, POS}, {NEG, NEG}, {POS, POS}, 64, saw);
      tick();
      check_eq("mask_no_rst", saw, 1'b0);
      check_eq("mask_count", rst_count, 16'd0);
      rx_if.power_trigger = 1'b0;

      // Length window
      min_th = 16'd14; max_th = 16'd1600;
      sig_pulse(16'd10);
      exp_count++;
      check_eq("len_short_rst", receiver_rst, 1'b1);
      check_eq("len_short_cause", rst_cause, 3'b010);
      check_eq("len_short_count", rst_count, exp_count);
      pulse_and_holdoff("len");
      sig_pulse(16'd1500);
      check_eq("len_mid_no_rst", receiver_rst, 1'b0);
      sig_pulse(16'd14);
      check_eq("len_min_edge", receiver_rst, 1'b0);
      sig_pulse(16'd1600);
      check_eq("len_max_edge", receiver_rst, 1'b0);
      check_eq("len_ok_count", rst_count, exp_count);
      sig_pulse(16'd1601);
      exp_count++;
      check_eq("len_long_rst", receiver_rst, 1'b1);
      check_eq("len_long_count", rst_count, exp_count);
      pulse_and_holdoff("len_long");

      // Demod timeout
      timeout_th = 20'd1000;
      rx_if.demod_is_ongoing = 1'b1;
      n = 0;
      while (receiver_rst !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      exp_count++;
      check_eq("to_latency", n, 1000);
      check_eq("to_cause", rst_cause, 3'b100);
      check_eq("to_count", rst_count, exp_count);
      rx_if.demod_is_ongoing = 1'b0;
      pulse_and_holdoff("to");
      rx_if.demod_is_ongoing = 1'b1;
      saw = 1'b0;
      for (int i = 1; i <= 1100; i++) begin
         rx_if.pkt_done = (i == 900);
         tick();
         if (receiver_rst) saw = 1'b1;
      end
      rx_if.pkt_done = 1'b0;
      rx_if.demod_is_ongoing = 1'b0;
      timeout_th = 20'd0;
      check_eq("to_pktdone_no_rst", saw, 1'b0);
      check_eq("to_pktdone_count", rst_count, exp_count);

      // Length and DC window end in the same cycle, then a fault during holdoff
      rx_if.power_trigger = 1'b1;
      dc_stream({POS, POS}, {POS, POS}, 32'h0, 63, saw);
      rx_if.signal_len = 16'd10;
      rx_if.sig_valid  = 1'b1;
      dc_stream({POS, POS}, {POS, POS}, 32'h0, 1, saw);
      rx_if.sig_valid  = 1'b0;
      rx_if.power_trigger = 1'b0;
      exp_count++;
      check_eq("sim_rst", receiver_rst, 1'b1);
      check_eq("sim_cause", rst_cause, 3'b011);
      check_eq("sim_count", rst_count, exp_count);
      for (int i = 0; i < 5; i++) tick();
      check_eq("sim_in_holdoff", wd_state, 2'd3);
      sig_pulse(16'd10);
      check_eq("holdoff_ignore_rst", receiver_rst, 1'b0);
      n = 0;
      while (wd_state !== 2'd1 && n < 100) begin
         tick();
         n++;
      end
      check_eq("holdoff_back_monitor", wd_state, 2'd1);
      check_eq("holdoff_ignore_count", rst_count, exp_count);
      check_eq("holdoff_ignore_cause", rst_cause, 3'b011);

      // Asynchronous reset in the middle of a pulse
      sig_pulse(16'd10);
      tick();
      check_eq("async_pre_rst", receiver_rst, 1'b1);
      rst_n = 1'b0;
      #1;
      check_eq("async_rst", receiver_rst, 1'b0);
      check_eq("async_count", rst_count, 16'd0);
      check_eq("async_cause", rst_cause, 3'b000);
      check_eq("async_state", wd_state, 2'd0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check_eq("async_recover", wd_state, 2'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
